// File: rtl/mz_video_pkg.sv
// mz_video_pkg: shared constants, phase numbers and FSM state type for the text fetcher
package mz_video_pkg;
  localparam int CHARS_PER_LINE = 40;
  localparam int CELL_W = 8;
  localparam logic [5:0] LAST_CELL = 6'(CHARS_PER_LINE - 1);
  localparam logic [2:0] PH_ADDR = 3'd0;
  localparam logic [2:0] PH_CODE = 3'd2;
  localparam logic [2:0] PH_CG = 3'd3;
  localparam logic [2:0] PH_FONT = 3'd5;
  localparam logic [2:0] PH_CGOFF = 3'd6;
  localparam logic [2:0] PH_LOAD = 3'(CELL_W - 1);
  typedef enum logic [1:0] {IDLE, PREFETCH, ACTIVE} state_t;
endpackage

// File: rtl/mz_text_fetch_if.sv
// mz_text_fetch_if: VRAM + character generator bus
// vram_addr/vram_data: synchronous VRAM read; cg_addr/cg_en/cg_data: font ROM read
interface mz_text_fetch_if;
  logic [9:0] vram_addr;
  logic [7:0] vram_data;
  logic [10:0] cg_addr;
  logic cg_en;
  logic [7:0] cg_data;
  modport master(output vram_addr, cg_addr, cg_en, input vram_data, cg_data);
  modport slave(input vram_addr, cg_addr, cg_en, output vram_data, cg_data);
endinterface

// File: rtl/mz_pix_shift8.sv
// mz_pix_shift8: 8-bit load/shift-left pixel register
// clk, rst_n (sync active-low), load (takes din, wins over shift), shift, din[7:0], msb = current pixel
module mz_pix_shift8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] din,
  output logic       msb
);
  logic [7:0] sr_q, sr_d;
  always_comb sr_d = load ? din : shift ? {sr_q[6:0], 1'b0} : sr_q;
  always_ff @(posedge clk) sr_q <= !rst_n ? 8'h00 : sr_d;
  assign msb = sr_q[7];
endmodule

// File: rtl/mz_text_fetch.sv
// mz_text_fetch: text-mode scan-line fetcher and pixel serialiser (40 cells x 8 pixels)
// clk, rst_n (sync active-low), pix_ce (pixel enable), line_start (pulse), row_base/row/invert (latched
// at line_start), mem (VRAM + char generator master), pixel (serial video), active (display window)
module mz_text_fetch
  import mz_video_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pix_ce,
  input  logic                   line_start,
  input  logic [9:0]             row_base,
  input  logic [2:0]             row,
  input  logic                   invert,
  mz_text_fetch_if.master        mem,
  output logic                   pixel,
  output logic                   active
);
  state_t state_q, state_d;
  logic [2:0] ph_q, ph_d, row_q, row_d;
  logic [5:0] cell_q, cell_d;
  logic [9:0] base_q, base_d, vaddr_q, vaddr_d;
  logic [10:0] cga_q, cga_d;
  logic cgen_q, cgen_d, inv_q, inv_d;
  logic [7:0] code_q, code_d, font_q, font_d, sh_din;
  logic run, last, fetch, sh_load, sh_shift, msb;
  always_comb begin
    run = pix_ce && state_q != IDLE;
    last = state_q == ACTIVE && cell_q == LAST_CELL;
    // the last displayed cell has no successor to fetch
    fetch = run && !last;
    state_d = state_q;
    ph_d = ph_q;
    cell_d = cell_q;
    base_d = base_q;
    row_d = row_q;
    inv_d = inv_q;
    vaddr_d = vaddr_q;
    cga_d = cga_q;
    cgen_d = cgen_q;
    code_d = code_q;
    font_d = font_q;
    sh_load = 1'b0;
    sh_shift = 1'b0;
    sh_din = 8'h00;
    if (line_start) begin
      state_d = PREFETCH;
      ph_d = 3'd0;
      cell_d = 6'd0;
      base_d = row_base;
      row_d = row;
      inv_d = invert;
      cgen_d = 1'b0;
      sh_load = 1'b1;
    end else if (run) begin
      ph_d = ph_q + 3'd1;
      // while displaying cell n the fetcher works on cell n+1
      if (fetch && ph_q == PH_ADDR) vaddr_d = base_q + (state_q == ACTIVE ? 10'(cell_q) + 10'd1 : 10'd0);
      if (fetch && ph_q == PH_CODE) code_d = mem.vram_data;
      if (fetch && ph_q == PH_CG) begin
        cga_d = {code_q, row_q};
        cgen_d = 1'b1;
      end
      if (fetch && ph_q == PH_FONT) font_d = mem.cg_data;
      if (ph_q == PH_CGOFF) cgen_d = 1'b0;
      if (ph_q == PH_LOAD) begin
        sh_load = 1'b1;
        sh_din = last ? 8'h00 : font_q ^ {8{inv_q}};
        state_d = last ? IDLE : ACTIVE;
        cell_d = state_q == ACTIVE && !last ? cell_q + 6'd1 : cell_q;
      end else sh_shift = state_q == ACTIVE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q <= 3'd0;
      cell_q <= 6'd0;
      base_q <= 10'd0;
      row_q <= 3'd0;
      inv_q <= 1'b0;
      vaddr_q <= 10'd0;
      cga_q <= 11'd0;
      cgen_q <= 1'b0;
      code_q <= 8'h00;
      font_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      cell_q <= cell_d;
      base_q <= base_d;
      row_q <= row_d;
      inv_q <= inv_d;
      vaddr_q <= vaddr_d;
      cga_q <= cga_d;
      cgen_q <= cgen_d;
      code_q <= code_d;
      font_q <= font_d;
    end
  end
  mz_pix_shift8 u_shift (
    .clk(clk),
    .rst_n(rst_n),
    .load(sh_load),
    .shift(sh_shift),
    .din(sh_din),
    .msb(msb)
  );
  assign mem.vram_addr = vaddr_q;
  assign mem.cg_addr = cga_q;
  assign mem.cg_en = cgen_q;
  assign active = state_q == ACTIVE;
  assign pixel = active && msb;
endmodule

// File: tb/tb_mz_text_fetch.sv
// tb_mz_text_fetch: table-driven and randomized check of mz_text_fetch against a tick-indexed line model
module tb_mz_text_fetch;
  logic clk = 1'b0;
  logic rst_n, pix_ce, line_start, invert, pixel, active;
  logic [9:0] row_base;
  logic [2:0] row;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] vram [1024];
  logic [7:0] font [2048];
  logic [9:0] cur_rb;
  logic [2:0] cur_row;
  logic cur_inv;
  mz_text_fetch_if mem_if();
  mz_text_fetch dut (
    .clk(clk),
    .rst_n(rst_n),
    .pix_ce(pix_ce),
    .line_start(line_start),
    .row_base(row_base),
    .row(row),
    .invert(invert),
    .mem(mem_if),
    .pixel(pixel),
    .active(active)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (pix_ce) mem_if.vram_data <= vram[mem_if.vram_addr];
  assign mem_if.cg_data = mem_if.cg_en ? font[mem_if.cg_addr] : 8'h00;
  initial begin
    #2ms;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end
  typedef struct {
    logic [9:0] rb;
    logic [2:0] row;
    logic inv;
    int div;
    int vmode;
    int exp_lit;
  } vec_t;
  vec_t vt [6];
  task automatic cmp(input string nm, input int k, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s tick=%0d got=%0h want=%0h", nm, k, act, exp);
    end
  endtask
  task automatic load_mem(input int mode);
    for (int i = 0; i < 1024; i++) vram[i] = mode == 0 ? 8'(i) : mode == 1 ? 8'h00 : 8'($urandom);
    for (int a = 0; a < 2048; a++) font[a] = mode == 2 ? 8'($urandom) : 8'(a >> 3);
  endtask
  function automatic logic [7:0] cell_code(input int c);
    logic [9:0] a;
    a = 10'((int'(cur_rb) + c) % 1024);
    return vram[a];
  endfunction
  function automatic logic [7:0] exp_byte(input int c);
    return font[{cell_code(c), cur_row}] ^ {8{cur_inv}};
  endfunction
  // expected outputs after k pixel ticks since line_start
  task automatic check(input int k);
    int f, j;
    logic [7:0] b;
    logic ea, ep, ecg;
    ea = k >= 8 && k < 328;
    j = k - 8;
    ep = 1'b0;
    if (ea) begin
      b = exp_byte(j / 8);
      ep = b[7 - (j % 8)];
    end
    f = k >= 1 ? (k - 1) / 8 : 0;
    ecg = k >= 1 && f <= 39 && ((k - 1) % 8) inside {[3:5]};
    cmp("active", k, int'(active), int'(ea));
    cmp("pixel", k, int'(pixel), int'(ep));
    cmp("cg_en", k, int'(mem_if.cg_en), int'(ecg));
    if (k >= 1) cmp("vram_addr", k, int'(mem_if.vram_addr), (int'(cur_rb) + (f > 39 ? 39 : f)) % 1024);
    if (ecg) cmp("cg_addr", k, int'(mem_if.cg_addr), int'({cell_code(f), cur_row}));
  endtask
  task automatic run_line(input logic [9:0] rb, input logic [2:0] r, input logic inv, input int div,
                          input int stop_k, output int n_act, output int n_lit);
    int k, cyc;
    logic tk;
    k = 0;
    cyc = 0;
    cur_rb = rb;
    cur_row = r;
    cur_inv = inv;
    row_base = rb;
    row = r;
    invert = inv;
    line_start = 1'b1;
    pix_ce = 1'b1;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    row_base = 10'($urandom);
    row = 3'($urandom);
    invert = 1'($urandom);
    n_act = 0;
    n_lit = 0;
    check(0);
    while (k < stop_k) begin
      pix_ce = (cyc % div) == div - 1;
      tk = pix_ce;
      cyc++;
      @(posedge clk);
      #1;
      if (tk) k++;
      check(k);
      if (tk) begin
        n_act += int'(active);
        n_lit += int'(pixel);
      end
    end
  endtask
  task automatic check_zero(input string nm);
    cmp({nm, "_active"}, 0, int'(active), 0);
    cmp({nm, "_pixel"}, 0, int'(pixel), 0);
    cmp({nm, "_cg_en"}, 0, int'(mem_if.cg_en), 0);
    cmp({nm, "_vram_addr"}, 0, int'(mem_if.vram_addr), 0);
    cmp({nm, "_cg_addr"}, 0, int'(mem_if.cg_addr), 0);
  endtask
  initial begin
    int na, nl;
    vt[0] = '{10'h000, 3'd3, 1'b0, 1, 0, 100};
    vt[1] = '{10'h000, 3'd3, 1'b0, 3, 0, 100};
    vt[2] = '{10'h000, 3'd5, 1'b1, 1, 1, 320};
    vt[3] = '{10'h3F0, 3'd3, 1'b0, 1, 0, 148};
    vt[4] = '{10'($urandom), 3'($urandom), 1'($urandom), 1, 2, -1};
    vt[5] = '{10'($urandom), 3'($urandom), 1'($urandom), 2, 2, -1};
    rst_n = 1'b0;
    pix_ce = 1'b1;
    line_start = 1'b0;
    row_base = 10'd0;
    row = 3'd0;
    invert = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load_mem(vt[i].vmode);
      run_line(vt[i].rb, vt[i].row, vt[i].inv, vt[i].div, 336, na, nl);
      cmp("active_ticks", i, na, 320);
      if (vt[i].exp_lit >= 0) cmp("lit_count", i, nl, vt[i].exp_lit);
    end
    load_mem(0);
    run_line(10'h000, 3'd3, 1'b0, 1, 8 + 20 * 8 + 3, na, nl);
    run_line(10'h000, 3'd3, 1'b0, 1, 336, na, nl);
    cmp("abort_active_ticks", 0, na, 320);
    cmp("abort_lit_count", 0, nl, 100);
    run_line(10'h155, 3'd1, 1'b0, 1, 8 + 10 * 8 + 2, na, nl);
    rst_n = 1'b0;
    line_start = 1'b1;
    pix_ce = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midreset");
    rst_n = 1'b1;
    line_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      cmp("idle_active", c, int'(active), 0);
      cmp("idle_cg_en", c, int'(mem_if.cg_en), 0);
      cmp("idle_vram_addr", c, int'(mem_if.vram_addr), 0);
    end
    run_line(10'h000, 3'd3, 1'b0, 1, 336, na, nl);
    cmp("post_reset_lit", 0, nl, 100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
